// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the 64-bit program counter and fetches one 32-bit
// instruction per req/ack transaction into a single-entry output buffer.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   next_pc_in          next PC returned from the downstream next-PC mux
//   pc_plus_step        combinational pc_reg + PC_STEP (mux input b)
//   flush               redirect: drop buffered/in-flight instruction, load next_pc_in
//   stall               decode cannot accept the buffered instruction
//   imem_req/imem_addr  registered instruction-memory request and address
//   imem_ack/imem_rdata memory completion and instruction word
//   instr_valid/instr_out/pc_out  buffered instruction and its PC
//   misaligned          sticky: a PC load with bits[1:0] != 0 was attempted
//   fetch_count         instructions accepted by decode (wraps)
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] next_pc_in,
    output logic [63:0] pc_plus_step,
    input  logic        flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [63:0] pc_out,
    output logic        misaligned,
    output logic [31:0] fetch_count
);

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e             state_q,   state_d;
    logic [PC_W-1:0]    pc_q,      pc_d;
    logic               req_q,     req_d;
    logic [PC_W-1:0]    addr_q,    addr_d;
    logic               valid_q,   valid_d;
    logic [INSTR_W-1:0] instr_q,   instr_d;
    logic [PC_W-1:0]    pc_out_q,  pc_out_d;
    logic               mis_q,     mis_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               discard_q, discard_d;

    logic accept;
    logic load_pc;
    logic npc_bad;

    assign pc_plus_step = pc_q + PC_W'(PC_STEP);
    assign accept       = valid_q & ~stall;
    assign npc_bad      = |next_pc_in[1:0];

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        mis_d     = mis_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        load_pc   = 1'b0;

        // Buffer drain applies in every state; flush wins and suppresses the count
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (flush) begin
                    load_pc = 1'b1;
                end else begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (flush) begin
                        load_pc   = 1'b1;
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = addr_q;
                        valid_d  = 1'b1;
                        load_pc  = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (flush) begin
                    // Request cannot be withdrawn: remember to drop its data
                    load_pc   = 1'b1;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    load_pc = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every PC load is screened for alignment; a bad target halts fetch
        if (load_pc) begin
            if (npc_bad) begin
                mis_d     = 1'b1;
                discard_d = 1'b0;
                state_d   = HALT;
            end else begin
                pc_d = next_pc_in;
            end
        end

        req_d = (state_d == FETCH);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_out_q  <= '0;
            mis_q     <= 1'b0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            mis_q     <= mis_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign misaligned  = mis_q;
    assign fetch_count = cnt_q;

endmodule
